rr_mult_pp_pipe: RTL and testbench
==================================

Name: rR_mult_pp_pipe

Overview:
- Pipelined, handshaked successor to the combinational radix-R partial-product generator used in the MSDF online multiplier.
- Computes pp = (NEG ? -b : b) * A. A is a (J+3)-digit redundant signed-digit vector; b is one signed digit. The result is a (J+4)-digit redundant vector.
- Adds a 2-stage registered datapath, valid/ready flow control with stall, a subtract mode, and digit-range error detection.
- Sits between the online-multiplier operand selector and its residual adder.

Parameters:
- J, 0, online delay index; A has J+3 digits, pp has J+4 digits.
- RADIX, 4, power of two ≥4; digit width D = clog2(RADIX)+1, two's complement.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- in_a  in  D*(J+3)  A; digit i at bits [D*i +: D]; digit 0 is least significant.
- in_b  in  D  multiplier digit b.
- in_neg  in  1  1 = produce -b*A.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- out_pp  out  D*(J+4)  partial product, same digit layout as in_a.
- out_err  out  1  beat contained a digit equal to -RADIX (out of legal set).

Behaviour:
- Legal digit set: [-(RADIX-1), RADIX-1].
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_pp=0, out_err=0, all stage registers 0.
- Transfer rule: a beat transfers when valid&&ready on the same edge.
- Stage 1 (capture on input transfer):
  - b' = in_neg ? -in_b : in_b.
  - For each i: p_i = a_i*b'; ub_i = p_i/RADIX truncated toward zero; lb_i = p_i - ub_i*RADIX.
  - Therefore |ub_i| ≤ RADIX-2 and |lb_i| ≤ RADIX-1.
  - Even i writes lb_i to EVEN digit i and ub_i to EVEN digit i+1. Odd i writes to ODD the same way.
  - Unwritten digits are 0.
  - err1 = any a_i == -RADIX or in_b == -RADIX. Offending digits are treated as 0 in the product.
- Stage 2: out_pp <= rRp_add(EVEN, ODD) with WIDTH=J+4, registered. out_err <= err1.
- Latency: exactly 2 cycles from input transfer to out_valid when out_ready=1. Throughput is 1 beat/cycle.
- Flow control:
  - s2 advances when !out_valid || out_ready.
  - s1 advances when !s1_valid || s2 advances.
  - in_ready = !s1_valid || s2 advances. This is combinational from out_ready; no skid buffer.
- Stall: while out_valid && !out_ready, out_pp and out_err hold stable and no beat is lost or duplicated.
- Simultaneous drain and fill in the same cycle is allowed; a full pipeline with out_ready=1 keeps in_ready=1.
- Value invariant: Σ out_pp_k*RADIX^k == b'*Σ a_i*RADIX^i for every legal beat.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops immediately (asynchronous).
- in_valid while in_ready=0: the input is ignored, and the source must hold it (AXI-style).

Decomposition:
- Package rR_pkg: D-from-RADIX function, digit typedef, function digit_split(p) returning {ub, lb}, constant DIGIT_MIN_LEGAL.
- Sub-module rR_digit_mul_split (one digit × one digit → ub, lb, err), instantiated J+3 times.
- Existing rRp_add is reused for stage 2.

Test Plan:
- RADIX=4, J=0: A digits (a2,a1,a0)=(1,2,3) (value 27), b=3, neg=0 → out_valid 2 cycles later; digit-weighted out_pp value = 81; out_err=0.
- Same A, b=3, neg=1 → value -81. Then b=-2, neg=0 → value -54. Back-to-back beats give outputs on consecutive cycles.
- b=0 or A all zero → value 0. A all 3s (63), b=-3 → -189, with every digit within the legal range.
- a0=-4 (=-RADIX), b=1 → out_err=1 on that beat only; the next legal beat gives out_err=0.
- Stream 6 beats with out_ready held low for 3 cycles mid-stream: in_ready drops once 2 beats are buffered; out_pp is stable while stalled; all 6 results arrive in order, none lost or duplicated.
- Assert rst_n low with 2 beats in flight → out_valid=0 and out_pp=0 immediately; after release, the first new beat emerges 2 cycles after acceptance.
- Random legal stimulus with random out_ready, RADIX∈{4,8,16}, J∈{0,2,5} → value invariant holds and beat ordering is preserved.

Source files
------------

// File: rtl/rr_mult_pp_pipe_pkg.sv
// Shared digit helpers for the pipelined radix-R partial-product generator.
package rR_pkg;
    localparam int STAGES = 2;
    localparam int MAX_DW = 16;

    // Radix-independent digit container; blocks truncate to their own D.
    typedef logic signed [MAX_DW-1:0] digit_t;

    typedef struct packed {
        digit_t ub;
        digit_t lb;
    } split_t;

    function automatic int digit_w(input int radix);
        return $clog2(radix) + 1;
    endfunction

    function automatic int digit_min_legal(input int radix);
        return -(radix - 1);
    endfunction

    // Signed division truncates toward zero, so lb keeps the sign of p.
    function automatic split_t digit_split(input int p, input int radix);
        split_t s;
        s.ub = digit_t'(p / radix);
        s.lb = digit_t'(p - (p / radix) * radix);
        return s;
    endfunction
endpackage

// File: rtl/rr_mult_pp_pipe_if.sv
// Valid/ready bundle between the operand selector, the pp pipe and the residual adder.
interface rr_mult_pp_pipe_if
    import rR_pkg::*;
#(
    parameter int J     = 0,
    parameter int RADIX = 4
);
    localparam int D = digit_w(RADIX);

    logic                   in_valid;
    logic                   in_ready;
    logic [D*(J+3)-1:0]     in_a;
    logic [D-1:0]           in_b;
    logic                   in_neg;
    logic                   out_valid;
    logic                   out_ready;
    logic [D*(J+4)-1:0]     out_pp;
    logic                   out_err;

    modport master (
        output in_valid, in_a, in_b, in_neg, out_ready,
        input  in_ready, out_valid, out_pp, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_neg, out_ready,
        output in_ready, out_valid, out_pp, out_err
    );
endinterface

// File: rtl/rr_mult_pp_pipe_add.sv
// Carry-free radix-R signed-digit adder; each output digit depends only on two digit positions.
module rRp_add
    import rR_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int RADIX = 4,
    parameter int D     = digit_w(RADIX)
) (
    input  logic [WIDTH-1:0][D-1:0] x_i,
    input  logic [WIDTH-1:0][D-1:0] y_i,
    output logic [WIDTH-1:0][D-1:0] z_o
);
    int w, t_in, t_out;

    // Transfer +-1 once |w| reaches R-1, leaving an interim digit of magnitude <= R-2
    // so adding the incoming transfer stays inside the legal set.
    always_comb begin
        z_o   = '0;
        w     = 0;
        t_in  = 0;
        t_out = 0;
        for (int k = 0; k < WIDTH; k++) begin
            w = int'(signed'(x_i[k])) + int'(signed'(y_i[k]));
            if (w >= RADIX - 1)       t_out = 1;
            else if (w <= -(RADIX - 1)) t_out = -1;
            else                      t_out = 0;
            z_o[k] = D'(w - t_out * RADIX + t_in);
            t_in   = t_out;
        end
    end
endmodule

// File: rtl/rr_mult_pp_pipe_split.sv
// One digit times one digit, split into an upper and lower radix-R digit.
module rR_digit_mul_split
    import rR_pkg::*;
#(
    parameter int RADIX = 4,
    parameter int D     = digit_w(RADIX)
) (
    input  logic signed [D-1:0] a_i,
    input  logic signed [D-1:0] b_i,
    output logic signed [D-1:0] ub_o,
    output logic signed [D-1:0] lb_o,
    output logic                err_o
);
    logic signed [D-1:0] a_eff;
    split_t              sp;

    always_comb begin
        err_o = int'(a_i) < digit_min_legal(RADIX);
        a_eff = err_o ? '0 : a_i;
        sp    = digit_split(int'(a_eff) * int'(b_i), RADIX);
        ub_o  = D'(sp.ub);
        lb_o  = D'(sp.lb);
    end
endmodule

// File: rtl/rr_mult_pp_pipe.sv
// Two-stage valid/ready pipeline computing pp = (neg ? -b : b) * A in radix-R signed digits.
module rr_mult_pp_pipe
    import rR_pkg::*;
#(
    parameter int J     = 0,
    parameter int RADIX = 4
) (
    input logic               clk,
    input logic               rst_n,
    rr_mult_pp_pipe_if.slave  bus
);
    localparam int D  = digit_w(RADIX);
    localparam int NA = J + 3;
    localparam int NP = J + 4;

    logic                    adv1, adv2, fire_in;
    logic                    b_err;
    logic signed [D-1:0]     b0, b_eff;
    logic [NA-1:0][D-1:0]    ub_w, lb_w;
    logic [NA-1:0]           aerr_w;
    logic [NP-1:0][D-1:0]    even_d, odd_d, sum_w;
    logic                    err1_d;

    logic [STAGES:1]         vld_pipe_q;
    logic [NP-1:0][D-1:0]    even_q, odd_q, pp_q;
    logic                    err1_q, err_q;

    // No skid buffer: in_ready ripples combinationally from out_ready.
    assign adv2    = !vld_pipe_q[2] || bus.out_ready;
    assign adv1    = !vld_pipe_q[1] || adv2;
    assign fire_in = bus.in_valid && adv1;

    assign b_err = int'(signed'(bus.in_b)) < digit_min_legal(RADIX);
    assign b0    = b_err ? '0 : signed'(bus.in_b);
    assign b_eff = bus.in_neg ? -b0 : b0;

    for (genvar i = 0; i < NA; i++) begin : g_lane
        rR_digit_mul_split #(.RADIX(RADIX), .D(D)) u_split (
            .a_i   (bus.in_a[D*i +: D]),
            .b_i   (b_eff),
            .ub_o  (ub_w[i]),
            .lb_o  (lb_w[i]),
            .err_o (aerr_w[i])
        );
    end

    // Even and odd lanes land in separate vectors so no digit is written twice.
    always_comb begin
        even_d = '0;
        odd_d  = '0;
        for (int i = 0; i < NA; i++) begin
            if (i % 2 == 0) begin
                even_d[i]   = lb_w[i];
                even_d[i+1] = ub_w[i];
            end else begin
                odd_d[i]    = lb_w[i];
                odd_d[i+1]  = ub_w[i];
            end
        end
        err1_d = b_err || (|aerr_w);
    end

    rRp_add #(.WIDTH(NP), .RADIX(RADIX), .D(D)) u_add (
        .x_i (even_q),
        .y_i (odd_q),
        .z_o (sum_w)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            even_q     <= '0;
            odd_q      <= '0;
            err1_q     <= 1'b0;
            pp_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            if (adv1) vld_pipe_q[1] <= bus.in_valid;
            if (fire_in) begin
                even_q <= even_d;
                odd_q  <= odd_d;
                err1_q <= err1_d;
            end
            if (adv2) begin
                vld_pipe_q[2] <= vld_pipe_q[1];
                if (vld_pipe_q[1]) begin
                    pp_q  <= sum_w;
                    err_q <= err1_q;
                end
            end
        end
    end

    assign bus.in_ready  = adv1;
    assign bus.out_valid = vld_pipe_q[2];
    assign bus.out_pp    = pp_q;
    assign bus.out_err   = err_q;
endmodule

// File: tb/tb_rr_mult_pp_pipe.sv
// Directed table, stall/reset sequences on RADIX=4 J=0; random scoreboard on RADIX=16 J=2.
module tb_rr_mult_pp_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_mult_pp_pipe_if #(.J(0), .RADIX(4))  ifa ();
    rr_mult_pp_pipe_if #(.J(2), .RADIX(16)) ifb ();

    rr_mult_pp_pipe #(.J(0), .RADIX(4))  dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
    rr_mult_pp_pipe #(.J(2), .RADIX(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

    typedef struct {
        int     a2, a1, a0;
        int     b;
        bit     neg;
        longint exp_val;
        bit     exp_err;
        string  name;
    } vec_t;

    vec_t       vecs[10];
    int         checks = 0;
    int         errors = 0;
    int         n_in, n_out, sent, got, d, bv;
    bit         stalled_prev, acc, neg;
    logic [11:0] held;
    longint     av, w, pend;
    longint     expq[$];

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Digit-weighted value of a packed digit vector; radix is 2^(d-1).
    function automatic longint dval(input logic [63:0] pp, input int dw, input int n);
        longint v = 0;
        longint wt = 1;
        longint dig;
        for (int k = 0; k < n; k++) begin
            dig = longint'((pp >> (dw*k)) & ((64'd1 << dw) - 1));
            if (dig >= (longint'(1) << (dw-1))) dig -= (longint'(1) << dw);
            v  += dig * wt;
            wt *= longint'(1) << (dw-1);
        end
        return v;
    endfunction

    function automatic int nbad(input logic [63:0] pp, input int dw, input int n);
        int c = 0;
        for (int k = 0; k < n; k++)
            if (((pp >> (dw*k)) & ((64'd1 << dw) - 1)) == (64'd1 << (dw-1))) c++;
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input vec_t v);
        ifa.in_a   = {3'(v.a2), 3'(v.a1), 3'(v.a0)};
        ifa.in_b   = 3'(v.b);
        ifa.in_neg = v.neg;
    endtask

    initial begin
        rst_n = 1'b0;
        ifa.in_valid = 1'b0; ifa.in_a = '0; ifa.in_b = '0; ifa.in_neg = 1'b0; ifa.out_ready = 1'b1;
        ifb.in_valid = 1'b0; ifb.in_a = '0; ifb.in_b = '0; ifb.in_neg = 1'b0; ifb.out_ready = 1'b0;

        vecs[0] = '{1, 2, 3,  3, 1'b0,   81, 1'b0, "b3"};
        vecs[1] = '{1, 2, 3,  3, 1'b1,  -81, 1'b0, "b3_neg"};
        vecs[2] = '{1, 2, 3, -2, 1'b0,  -54, 1'b0, "bm2"};
        vecs[3] = '{1, 2, 3,  0, 1'b0,    0, 1'b0, "b0"};
        vecs[4] = '{0, 0, 0,  3, 1'b0,    0, 1'b0, "a0"};
        vecs[5] = '{3, 3, 3, -3, 1'b0, -189, 1'b0, "a3s_bm3"};
        vecs[6] = '{0, 0, -4, 1, 1'b0,    0, 1'b1, "a_minR"};
        vecs[7] = '{1, 2, 3,  1, 1'b0,   27, 1'b0, "after_err"};
        vecs[8] = '{-1, 0, 2, -3, 1'b1, -42, 1'b0, "neg_negb"};
        vecs[9] = '{1, 1, 1, -4, 1'b0,    0, 1'b1, "b_minR"};

        #12;
        check("rst_out_valid", ifa.out_valid, 0);
        check("rst_out_pp", 64'(ifa.out_pp), 0);
        check("rst_out_err", ifa.out_err, 0);
        check("rst_in_ready", ifa.in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            drive_a(vecs[i]);
            ifa.in_valid = 1'b1;
            check({vecs[i].name, "_in_ready"}, ifa.in_ready, 1);
            tick();
            ifa.in_valid = 1'b0;
            check({vecs[i].name, "_early_valid"}, ifa.out_valid, 0);
            tick();
            check({vecs[i].name, "_valid"}, ifa.out_valid, 1);
            check({vecs[i].name, "_value"}, dval(64'(ifa.out_pp), 3, 4), vecs[i].exp_val);
            check({vecs[i].name, "_err"}, ifa.out_err, vecs[i].exp_err);
            check({vecs[i].name, "_legal"}, nbad(64'(ifa.out_pp), 3, 4), 0);
        end
        tick();

        // back-to-back beats emerge on consecutive cycles
        drive_a(vecs[0]); ifa.in_valid = 1'b1; tick();
        check("b2b_early", ifa.out_valid, 0);
        drive_a(vecs[1]); tick();
        check("b2b_v0", ifa.out_valid, 1);
        check("b2b_val0", dval(64'(ifa.out_pp), 3, 4), 81);
        drive_a(vecs[2]); tick();
        ifa.in_valid = 1'b0;
        check("b2b_val1", dval(64'(ifa.out_pp), 3, 4), -81);
        tick();
        check("b2b_val2", dval(64'(ifa.out_pp), 3, 4), -54);
        tick();
        check("b2b_drained", ifa.out_valid, 0);

        // six beats with out_ready low for cycles 3..5
        n_in = 0; n_out = 0; stalled_prev = 1'b0; held = '0;
        for (int c = 0; c < 40 && n_out < 6; c++) begin
            ifa.out_ready = !(c >= 3 && c <= 5);
            if (n_in < 6) begin
                ifa.in_valid = 1'b1;
                ifa.in_a = {3'd0, 3'((n_in + 1) / 4), 3'((n_in + 1) % 4)};
                ifa.in_b = 3'd1; ifa.in_neg = 1'b0;
            end else ifa.in_valid = 1'b0;
            #3;
            check("stall_in_ready", ifa.in_ready, (c >= 3 && c <= 5) ? 0 : 1);
            if (stalled_prev) check("stall_hold", 64'(ifa.out_pp), 64'(held));
            stalled_prev = ifa.out_valid && !ifa.out_ready;
            held = ifa.out_pp;
            if (ifa.out_valid && ifa.out_ready) begin
                n_out++;
                check("stream_order", dval(64'(ifa.out_pp), 3, 4), n_out);
            end
            if (ifa.in_valid && ifa.in_ready) n_in++;
            tick();
        end
        check("stream_count", n_out, 6);
        ifa.in_valid = 1'b0; ifa.out_ready = 1'b1;
        tick(); tick();

        // reset with two beats in flight
        drive_a(vecs[0]); ifa.in_valid = 1'b1; tick();
        drive_a(vecs[1]); tick();
        ifa.in_valid = 1'b0;
        check("pre_rst_valid", ifa.out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", ifa.out_valid, 0);
        check("midrst_pp", 64'(ifa.out_pp), 0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        drive_a(vecs[0]); ifa.in_valid = 1'b1; tick();
        ifa.in_valid = 1'b0;
        check("postrst_early", ifa.out_valid, 0);
        tick();
        check("postrst_valid", ifa.out_valid, 1);
        check("postrst_value", dval(64'(ifa.out_pp), 3, 4), 81);

        // random legal beats, random backpressure, RADIX=16 J=2
        sent = 0; got = 0; pend = 0;
        for (int c = 0; c < 3000 && got < 100; c++) begin
            if (!ifb.in_valid && sent < 100 && $urandom_range(0, 3) != 0) begin
                av = 0; w = 1;
                for (int k = 0; k < 5; k++) begin
                    d = int'($urandom_range(0, 30)) - 15;
                    ifb.in_a[5*k +: 5] = 5'(d);
                    av += longint'(d) * w;
                    w *= 16;
                end
                bv  = int'($urandom_range(0, 30)) - 15;
                neg = 1'($urandom_range(0, 1));
                ifb.in_b = 5'(bv); ifb.in_neg = neg; ifb.in_valid = 1'b1;
                pend = longint'(neg ? -bv : bv) * av;
            end
            ifb.out_ready = ($urandom_range(0, 2) != 0);
            #3;
            if (ifb.out_valid && ifb.out_ready) begin
                check("rand_q_nonempty", expq.size() > 0, 1);
                if (expq.size() > 0) check("rand_value", dval(64'(ifb.out_pp), 5, 6), expq.pop_front());
                check("rand_err", ifb.out_err, 0);
                check("rand_legal", nbad(64'(ifb.out_pp), 5, 6), 0);
                got++;
            end
            acc = ifb.in_valid && ifb.in_ready;
            if (acc) begin
                expq.push_back(pend);
                sent++;
            end
            tick();
            if (acc) ifb.in_valid = 1'b0;
        end
        check("rand_count", got, 100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
